// File: rtl/robo_ctrl.sv
// Wall-following cleaning robot controller: sense -> decide -> issue command handshake.
// Optional step limit enabled by defining ROBO_STEP_LIMIT_EN.
module robo_ctrl #(
  parameter logic [15:0] MAX_STEPS   = 16'd1000,
  parameter int unsigned STUCK_TURNS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sensor_valid,
  input  logic        head,
  input  logic        left,
  input  logic        under,
  input  logic        barrier,
  input  logic        cmd_ready,
  output logic [2:0]  cmd,
  output logic        cmd_valid,
  output logic        busy,
  output logic        done,
  output logic        stuck,
  output logic [15:0] step_cnt
);

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned TURN_W = $clog2(STUCK_TURNS + 1);

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP    = 3'd0,
    CMD_FWD    = 3'd1,
    CMD_TURN_L = 3'd2,
    CMD_TURN_R = 3'd3,
    CMD_CLEAN  = 3'd4,
    CMD_REMOVE = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SENSE  = 3'd1,
    S_DECIDE = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e              r_state, w_state_nxt;
  cmd_e                r_cmd, w_cmd_nxt;
  logic                r_cmd_valid, w_cmd_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_stuck, w_stuck_nxt;
  logic [STEP_W-1:0]   r_step_cnt, w_step_nxt;
  logic [TURN_W-1:0]   r_turn_cnt, w_turn_nxt;
  logic                r_pend_fwd, w_pend_nxt;
  logic                r_head, r_left, r_under, r_barrier;
  logic                w_head_nxt, w_left_nxt, w_under_nxt, w_barrier_nxt;

  logic                w_xfer;
  logic [STEP_W-1:0]   w_step_inc;
  logic [TURN_W-1:0]   w_turn_inc;
  logic                w_limit_hit;

  assign w_xfer     = r_cmd_valid & cmd_ready;
  assign w_step_inc = (r_step_cnt == '1) ? r_step_cnt : r_step_cnt + STEP_W'(1);
  assign w_turn_inc = r_turn_cnt + TURN_W'(1);

`ifdef ROBO_STEP_LIMIT_EN
  assign w_limit_hit = (w_step_inc == MAX_STEPS);
`else
  logic w_unused_max;
  assign w_unused_max = ^MAX_STEPS;
  assign w_limit_hit  = 1'b0;
`endif

  // State and all outputs are registered together so they change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cmd       <= CMD_NOP;
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stuck     <= 1'b0;
      r_step_cnt  <= '0;
      r_turn_cnt  <= '0;
      r_pend_fwd  <= 1'b0;
      r_head      <= 1'b0;
      r_left      <= 1'b0;
      r_under     <= 1'b0;
      r_barrier   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_stuck     <= w_stuck_nxt;
      r_step_cnt  <= w_step_nxt;
      r_turn_cnt  <= w_turn_nxt;
      r_pend_fwd  <= w_pend_nxt;
      r_head      <= w_head_nxt;
      r_left      <= w_left_nxt;
      r_under     <= w_under_nxt;
      r_barrier   <= w_barrier_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_nxt       = r_cmd;
    w_cmd_valid_nxt = r_cmd_valid;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = r_done;
    w_stuck_nxt     = r_stuck;
    w_step_nxt      = r_step_cnt;
    w_turn_nxt      = r_turn_cnt;
    w_pend_nxt      = r_pend_fwd;
    w_head_nxt      = r_head;
    w_left_nxt      = r_left;
    w_under_nxt     = r_under;
    w_barrier_nxt   = r_barrier;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SENSE;
          w_step_nxt  = '0;
          w_turn_nxt  = '0;
          w_done_nxt  = 1'b0;
          w_stuck_nxt = 1'b0;
          w_pend_nxt  = 1'b0;
        end
      end
      S_SENSE: begin
        if (sensor_valid) begin
          w_head_nxt    = head;
          w_left_nxt    = left;
          w_under_nxt   = under;
          w_barrier_nxt = barrier;
          w_state_nxt   = S_DECIDE;
        end
      end
      S_DECIDE: begin
        w_state_nxt     = S_ISSUE;
        w_cmd_valid_nxt = 1'b1;
        w_pend_nxt      = 1'b0;
        if (r_under) begin
          w_cmd_nxt = CMD_CLEAN;
        end else if (!r_left) begin
          w_cmd_nxt  = CMD_TURN_L;
          w_pend_nxt = 1'b1;
        end else if (!r_head) begin
          w_cmd_nxt = CMD_FWD;
        end else if (r_barrier) begin
          w_cmd_nxt = CMD_REMOVE;
        end else begin
          w_cmd_nxt = CMD_TURN_R;
        end
      end
      S_ISSUE: begin
        if (w_xfer) begin
          w_cmd_nxt       = CMD_NOP;
          w_cmd_valid_nxt = 1'b0;
          w_state_nxt     = S_SENSE;
          case (r_cmd)
            CMD_TURN_L: begin
              // Left turn is always followed by a forward move without re-sensing.
              if (r_pend_fwd) begin
                w_cmd_nxt       = CMD_FWD;
                w_cmd_valid_nxt = 1'b1;
                w_pend_nxt      = 1'b0;
                w_state_nxt     = S_ISSUE;
              end
            end
            CMD_FWD: begin
              w_step_nxt = w_step_inc;
              w_turn_nxt = '0;
              if (w_limit_hit) begin
                w_state_nxt = S_HALT;
                w_done_nxt  = 1'b1;
                w_pend_nxt  = 1'b0;
              end
            end
            CMD_TURN_R: begin
              w_turn_nxt = w_turn_inc;
              if (w_turn_inc == TURN_W'(STUCK_TURNS)) begin
                w_state_nxt = S_HALT;
                w_stuck_nxt = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      S_HALT: ;
      default: begin
        w_state_nxt     = S_IDLE;
        w_cmd_nxt       = CMD_NOP;
        w_cmd_valid_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_SENSE) || (w_state_nxt == S_DECIDE) ||
                 (w_state_nxt == S_ISSUE);
  end

  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign stuck     = r_stuck;
  assign step_cnt  = r_step_cnt;

endmodule

// File: tb/tb_robo_ctrl.sv
// Randomized bench for robo_ctrl against a round-level behavioural model.
module tb_robo_ctrl;

  localparam logic [15:0] TB_MAX   = 16'd5;
  localparam int          TB_STUCK = 4;
  localparam logic [2:0]  C_NOP = 3'd0, C_FWD = 3'd1, C_TL = 3'd2, C_TR = 3'd3,
                          C_CLEAN = 3'd4, C_REMOVE = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sensor_valid = 1'b0;
  logic        head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd;
  logic        cmd_valid, busy, done, stuck;
  logic [15:0] step_cnt;

  int n_total = 0;
  int n_bad   = 0;

  int m_step, m_turns;
  bit m_halted, m_done, m_stuck;

  robo_ctrl #(.MAX_STEPS(TB_MAX), .STUCK_TURNS(TB_STUCK)) dut (
    .clk(clk), .reset(reset), .start(start), .sensor_valid(sensor_valid),
    .head(head), .left(left), .under(under), .barrier(barrier),
    .cmd_ready(cmd_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .done(done), .stuck(stuck), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_step = 0; m_turns = 0; m_halted = 0; m_done = 0; m_stuck = 0;
  endtask

  // Navigation rule: dirt first, then hug the left wall, then go ahead, clear obstacles, else turn right.
  function automatic logic [2:0] pick_cmd(input bit h, input bit l, input bit u, input bit b,
                                          output bit pend);
    pend = 0;
    if (u) return C_CLEAN;
    if (!l) begin pend = 1; return C_TL; end
    if (!h) return C_FWD;
    if (b) return C_REMOVE;
    return C_TR;
  endfunction

  task automatic model_xfer(input logic [2:0] c);
    if (c == C_FWD) begin
      if (m_step < 65535) m_step++;
      m_turns = 0;
`ifdef ROBO_STEP_LIMIT_EN
      if (m_step == int'(TB_MAX)) begin m_halted = 1; m_done = 1; end
`endif
    end else if (c == C_TR) begin
      m_turns++;
      if (m_turns == TB_STUCK) begin m_halted = 1; m_stuck = 1; end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd"}, 32'(cmd), 0);
    check({tag, "_valid"}, 32'(cmd_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_stuck"}, 32'(stuck), 0);
    check({tag, "_step"}, 32'(step_cnt), 0);
  endtask

  task automatic do_reset();
    reset = 0; start = 0; sensor_valid = 0; cmd_ready = 0;
    tick(); tick();
    check_idle("rst");
    reset = 1;
    tick();
    check_idle("post_rst");
    model_clear();
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    check("start_busy", 32'(busy), 1);
    check("start_valid", 32'(cmd_valid), 0);
    check("start_step", 32'(step_cnt), 0);
  endtask

  // Offer one command; hold cmd_ready low for 'stall' cycles, then complete the transfer.
  task automatic issue_xfer(input logic [2:0] exp, input int stall_in);
    int stall;
    stall = (stall_in < 0) ? int'($urandom_range(0, 3)) : stall_in;
    check("issue_valid", 32'(cmd_valid), 1);
    check("issue_cmd", 32'(cmd), 32'(exp));
    check("issue_busy", 32'(busy), 1);
    repeat (stall) begin
      cmd_ready = 0;
      sensor_valid = 1'($urandom);
      start = 1'($urandom);
      tick();
      check("stall_valid", 32'(cmd_valid), 1);
      check("stall_cmd", 32'(cmd), 32'(exp));
    end
    cmd_ready = 1;
    tick();
    sensor_valid = 0;
    start = 0;
    model_xfer(exp);
  endtask

  task automatic run_round(input bit h, input bit l, input bit u, input bit b, input int stall);
    logic [2:0] c;
    logic [3:0] junk;
    bit pend;
    repeat ($urandom_range(0, 3)) begin
      sensor_valid = 0;
      junk = 4'($urandom);
      {head, left, under, barrier} = junk;
      tick();
      check("sense_valid", 32'(cmd_valid), 0);
      check("sense_busy", 32'(busy), 1);
    end
    sensor_valid = 1;
    {head, left, under, barrier} = {h, l, u, b};
    tick();
    sensor_valid = 1'($urandom);
    junk = 4'($urandom);
    {head, left, under, barrier} = junk;
    cmd_ready = 1'($urandom);
    check("decide_valid", 32'(cmd_valid), 0);
    check("decide_cmd", 32'(cmd), 32'(C_NOP));
    tick();
    sensor_valid = 0;
    c = pick_cmd(h, l, u, b, pend);
    issue_xfer(c, stall);
    if (pend) issue_xfer(C_FWD, -1);
    cmd_ready = 0;
    check("post_valid", 32'(cmd_valid), 0);
    check("post_cmd", 32'(cmd), 32'(C_NOP));
    check("post_step", 32'(step_cnt), 32'(m_step));
    check("post_busy", 32'(busy), 32'(!m_halted));
    check("post_stuck", 32'(stuck), 32'(m_stuck));
    check("post_done", 32'(done), 32'(m_done));
  endtask

  task automatic halt_hold();
    repeat (3) begin
      start = 1; sensor_valid = 1; cmd_ready = 1;
      tick();
      check("halt_busy", 32'(busy), 0);
      check("halt_valid", 32'(cmd_valid), 0);
      check("halt_stuck", 32'(stuck), 32'(m_stuck));
      check("halt_done", 32'(done), 32'(m_done));
      check("halt_step", 32'(step_cnt), 32'(m_step));
    end
    start = 0; sensor_valid = 0; cmd_ready = 0;
  endtask

  initial begin
    logic [3:0] s;
    model_clear();

    // Directed: forward, left-turn pair, stalled clean, remove, then four right turns.
    do_reset();
    do_start();
    run_round(0, 1, 0, 0, -1);
    run_round(1, 0, 0, 0, 0);
    run_round(0, 0, 1, 0, 5);
    run_round(1, 1, 0, 1, -1);
    for (int i = 0; i < TB_STUCK && !m_halted; i++) run_round(1, 1, 0, 0, -1);
    check("dir_halted", 32'(m_halted), 1);
    halt_hold();

    // Reset in the middle of an offered command.
    do_reset();
    do_start();
    run_round(0, 1, 0, 0, 0);
    sensor_valid = 1;
    {head, left, under, barrier} = 4'b0100;
    tick();
    sensor_valid = 0;
    cmd_ready = 0;
    tick();
    check("mid_valid_before", 32'(cmd_valid), 1);
    check("mid_step_before", 32'(step_cnt), 1);
    reset = 0;
    #2;
    check_idle("mid_rst");

    // Random episodes.
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      do_start();
      for (int r = 0; r < 40 && !m_halted; r++) begin
        if ($urandom_range(0, 9) < 4) s = 4'b1100;
        else s = 4'($urandom);
        run_round(s[3], s[2], s[1], s[0], -1);
      end
      if (m_halted) halt_hold();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/robo_ctrl.md
ROBO_CTRL -- requirements
Module: robo_ctrl

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 16'd1000, forward-move limit (used only with ROBO_STEP_LIMIT_EN).
REQ-002 SHALL have parameter STUCK_TURNS, default 4, consecutive TURN_R commands without FWD that trigger stuck halt.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse starting navigation from IDLE.
REQ-006 SHALL have port sensor_valid  input  1  head/left/under/barrier valid this cycle.
REQ-007 SHALL have ports head, left, under, barrier  input  1 each  wall ahead, wall on left, dirt under robot, removable obstacle ahead.
REQ-008 SHALL have port cmd_ready  input  1  map memory accepts cmd.
REQ-009 SHALL have port cmd  output  3  0 NOP, 1 FWD, 2 TURN_L, 3 TURN_R, 4 CLEAN, 5 REMOVE; 6-7 never driven.
REQ-010 SHALL have port cmd_valid  output  1  cmd offered.
REQ-011 SHALL have ports busy, done, stuck  output  1 each  navigating, step limit reached, stuck halt.
REQ-012 SHALL have port step_cnt  output  16  accepted FWD count.

Function
REQ-013 SHALL implement states IDLE, SENSE, DECIDE, ISSUE, HALT.
REQ-014 IDLE: start=1 -> SENSE next cycle; clears step_cnt, turn counter, done, stuck; start ignored in other states.
REQ-015 SENSE: latches the four sensors on the edge where sensor_valid=1, then -> DECIDE; waits indefinitely otherwise.
REQ-016 DECIDE (one cycle) SHALL pick by priority: under=1 -> CLEAN; left=0 -> TURN_L with pending FWD; head=0 -> FWD; barrier=1 -> REMOVE; else TURN_R; then -> ISSUE.
REQ-017 ISSUE: cmd_valid=1, cmd held stable until transfer (rising edge with cmd_valid=1 and cmd_ready=1); cmd_valid SHALL NOT drop before transfer.
REQ-018 cmd_valid SHALL rise exactly 2 cycles after the sensor-accept edge; cmd_ready may be high already (zero-wait transfer).
REQ-019 After TURN_L transfer with pending FWD, SHALL stay in ISSUE with cmd=FWD next cycle, no re-sense; otherwise -> SENSE.
REQ-020 Each FWD transfer SHALL increment step_cnt (saturating at 16'hFFFF) and clear the turn counter.
REQ-021 Each TURN_R transfer SHALL increment the turn counter; on reaching STUCK_TURNS -> HALT with stuck=1.
REQ-022 Outside ISSUE cmd SHALL be 0 (NOP) and cmd_valid 0.
REQ-023 busy SHALL be 1 in SENSE, DECIDE, ISSUE; 0 in IDLE, HALT.
REQ-024 HALT SHALL be left only by reset; done/stuck hold.
REQ-025 sensor_valid in any state other than SENSE SHALL be ignored.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, cmd=0, cmd_valid=0, busy=0, done=0, stuck=0, step_cnt=0, turn counter=0, pending FWD cleared, including mid-transfer.
REQ-027 First state change after reset release SHALL occur no earlier than the first rising clk edge with reset=1.

Configuration
REQ-028 With ROBO_STEP_LIMIT_EN defined: FWD transfer making step_cnt == MAX_STEPS -> HALT with done=1 (takes precedence over pending FWD).
REQ-029 Without ROBO_STEP_LIMIT_EN: no step limit; done constant 0; navigation stops only via stuck or reset.

Verification
REQ-030 Start, sensors head=0 left=1 under=0 barrier=0, cmd_ready=1 -> cmd=1 two cycles after accept, step_cnt=1, back to SENSE.
REQ-031 Sensors left=0, cmd_ready=1 -> cmd=2 then cmd=3'd1 next cycle without SENSE, step_cnt +1.
REQ-032 Sensors under=1 left=0, cmd_ready held 0 for 5 cycles -> cmd=4, cmd_valid high and stable all 5 cycles, transfer on 6th.
REQ-033 Four consecutive sense rounds head=1 left=1 barrier=0 -> four cmd=3 transfers, then HALT, stuck=1, busy=0.
REQ-034 ROBO_STEP_LIMIT_EN, MAX_STEPS=3, head=0 left=1 always -> exactly 3 FWD, done=1; without macro -> FWD continues, done=0.
REQ-035 reset=0 asserted while cmd_valid=1 -> cmd_valid=0, step_cnt=0, IDLE immediately, before next clk edge.
